// File: rtl/gate_tt_pkg.sv
// Shared definitions for the 2-input gate truth-table checker:
// the FSM state encoding and the reference truth tables.
package gate_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Truth tables for 2-input gates: bit i is the output when the inputs equal i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage : gate_tt_pkg

// File: rtl/gate_tt_settle_timer.sv
// Loadable 4-bit down-counter measuring how long each vector is held
// before the gate output is sampled. It stops at zero and flags it.
module gate_tt_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: a load wins over a decrement; the counter never wraps below zero.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule : gate_tt_settle_timer

// File: rtl/gate_tt_checker.sv
// Sweeps every input vector into a combinational gate under test, holds each
// vector SETTLE_CYCLES+1 cycles, samples the gate output on the last cycle and
// compares it with EXPECTED_TT. Reports pass/fail, a mismatch count and the
// first failing vector. All outputs come straight from flops.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int                     N_IN          = 2,
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED_TT   = 4'b1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  localparam logic [N_IN-1:0] STIM_LAST  = '1;
  localparam logic [N_IN-1:0] STIM_ONE   = (N_IN)'(1);
  localparam logic [N_IN:0]   ERR_ONE    = (N_IN+1)'(1);
  localparam logic [3:0]      SETTLE_VAL = 4'(SETTLE_CYCLES);

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fev_q, fev_d;
  logic [N_IN-1:0] fvec_q, fvec_d;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;
  logic mismatch;

  gate_tt_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_VAL),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // An X or Z from the gate under test counts as a mismatch in simulation.
  assign mismatch = (dut_y !== EXPECTED_TT[stim_q]);

  // Sweep control: start acceptance, settle wait, sample/compare, advance or finish.
  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fvec_d   = fvec_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_HOLD;
          stim_d   = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fev_d    = 1'b0;
          fvec_d   = '0;
          tmr_load = 1'b1;
        end
      end

      ST_HOLD: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!fev_q) begin
              fev_d  = 1'b1;
              fvec_d = stim_q;
            end
          end
          if (stim_q == STIM_LAST) begin
            // Last vector sampled: verdict includes this final comparison.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            stim_d   = stim_q + STIM_ONE;
            tmr_load = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep and clears all results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule : gate_tt_checker

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker. Three checker instances with different
// widths, settle times and expected tables each drive a gate modelled as a
// plain lookup table. Expected sweep results are derived by comparing the gate
// table with the expected table bit by bit and are queued at start; a monitor
// pops and compares whenever a checker raises done.
module tb_gate_tt_checker;

  typedef struct {
    int err;
    bit fv;
    int fvec;
    bit pass;
    int start_edge;
    int len;
    int last;
  } exp_t;

  localparam int       N_OF  [3] = '{2, 2, 3};
  localparam int       S_OF  [3] = '{2, 1, 0};
  localparam bit [7:0] TT_OF [3] = '{8'h08, 8'h01, 8'h80};

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] y_v;
  logic [2:0] busy_v, done_v, pass_v, fev_v;
  logic [7:0] gt [3];

  logic [1:0] stim_a, stim_n, fvec_a, fvec_n;
  logic [2:0] stim_3, fvec_3, err_a, err_n;
  logic [3:0] err_3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  assign y_v[0] = gt[0][stim_a];
  assign y_v[1] = gt[1][stim_n];
  assign y_v[2] = gt[2][stim_3];

  gate_tt_checker #(.N_IN(2), .SETTLE_CYCLES(2), .EXPECTED_TT(4'b1000)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_y(y_v[0]), .stim(stim_a),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_a),
    .first_err_valid(fev_v[0]), .first_err_vec(fvec_a)
  );

  gate_tt_checker #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECTED_TT(4'b0001)) u_nor (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_y(y_v[1]), .stim(stim_n),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_n),
    .first_err_valid(fev_v[1]), .first_err_vec(fvec_n)
  );

  gate_tt_checker #(.N_IN(3), .SETTLE_CYCLES(0), .EXPECTED_TT(8'b1000_0000)) u_and3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_y(y_v[2]), .stim(stim_3),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_3),
    .first_err_valid(fev_v[2]), .first_err_vec(fvec_3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int get_stim(int k);
    case (k)
      0:       return int'(stim_a);
      1:       return int'(stim_n);
      default: return int'(stim_3);
    endcase
  endfunction

  function automatic int get_err(int k);
    case (k)
      0:       return int'(err_a);
      1:       return int'(err_n);
      default: return int'(err_3);
    endcase
  endfunction

  function automatic int get_fvec(int k);
    case (k)
      0:       return int'(fvec_a);
      1:       return int'(fvec_n);
      default: return int'(fvec_3);
    endcase
  endfunction

  function automatic void qpush(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qclear(int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Reference: a sweep visits every vector once; a vector fails where the gate
  // table and the expected table disagree.
  function automatic exp_t model(int k, logic [7:0] gate, int start_edge);
    exp_t e;
    int   nvec;
    nvec         = 1 << N_OF[k];
    e.err        = 0;
    e.fv         = 1'b0;
    e.fvec       = 0;
    for (int i = 0; i < nvec; i++) begin
      if (gate[i] != TT_OF[k][i]) begin
        e.err++;
        if (!e.fv) begin
          e.fv   = 1'b1;
          e.fvec = i;
        end
      end
    end
    e.pass       = (e.err == 0);
    e.start_edge = start_edge;
    e.len        = nvec * (S_OF[k] + 1);
    e.last       = nvec - 1;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: track busy duration and compare results each time done rises.
  initial begin
    int busy_len [3];
    bit busy_prev[3];
    bit done_prev[3];
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      busy_len[k]  = 0;
      busy_prev[k] = 1'b0;
      done_prev[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          busy_len[k]  = 0;
          busy_prev[k] = 1'b0;
          done_prev[k] = 1'b0;
        end else begin
          if (busy_v[k] && !busy_prev[k]) busy_len[k] = 0;
          if (busy_v[k]) busy_len[k]++;
          if (done_v[k] && !done_prev[k]) begin
            if (qsize(k) == 0) begin
              check($sformatf("unexpected_done[%0d]", k), 1, 0);
            end else begin
              e = qpop(k);
              check($sformatf("done_edge[%0d]", k), cyc, e.start_edge + e.len);
              check($sformatf("busy_len[%0d]", k), busy_len[k], e.len);
              check($sformatf("busy_at_done[%0d]", k), int'(busy_v[k]), 0);
              check($sformatf("err_count[%0d]", k), get_err(k), e.err);
              check($sformatf("first_err_valid[%0d]", k), int'(fev_v[k]), int'(e.fv));
              check($sformatf("first_err_vec[%0d]", k), get_fvec(k), e.fvec);
              check($sformatf("pass[%0d]", k), int'(pass_v[k]), int'(e.pass));
              check($sformatf("stim_last[%0d]", k), get_stim(k), e.last);
            end
          end
          busy_prev[k] = busy_v[k];
          done_prev[k] = done_v[k];
        end
      end
    end
  end

  task automatic check_reset(input int k);
    check($sformatf("rst_busy[%0d]", k), int'(busy_v[k]), 0);
    check($sformatf("rst_done[%0d]", k), int'(done_v[k]), 0);
    check($sformatf("rst_pass[%0d]", k), int'(pass_v[k]), 0);
    check($sformatf("rst_err[%0d]", k), get_err(k), 0);
    check($sformatf("rst_fev[%0d]", k), int'(fev_v[k]), 0);
    check($sformatf("rst_fvec[%0d]", k), get_fvec(k), 0);
    check($sformatf("rst_stim[%0d]", k), get_stim(k), 0);
  endtask

  // Issue a one-cycle start from a negedge; the cycle after acceptance must
  // show a cleared, busy checker driving vector 0.
  task automatic sweep(input int k, input logic [7:0] gate, output int start_edge);
    gt[k]      = gate;
    start_edge = cyc + 1;
    qpush(k, model(k, gate, start_edge));
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    check($sformatf("start_busy[%0d]", k), int'(busy_v[k]), 1);
    check($sformatf("start_done[%0d]", k), int'(done_v[k]), 0);
    check($sformatf("start_err[%0d]", k), get_err(k), 0);
    check($sformatf("start_fev[%0d]", k), int'(fev_v[k]), 0);
    check($sformatf("start_stim[%0d]", k), get_stim(k), 0);
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    while (qsize(k) != 0 && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (qsize(k) != 0) begin
      check($sformatf("done_timeout[%0d]", k), qsize(k), 0);
      qclear(k);
    end
  endtask

  task automatic pulse_at(input int k, input int edge_no);
    while (cyc + 1 < edge_no) @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  initial begin
    int e0;
    rst_n   = 1'b0;
    start_v = '0;
    for (int k = 0; k < 3; k++) gt[k] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) check_reset(k);

    // Correct AND, then OR, then stuck-at-0 against the AND table.
    sweep(0, 8'h08, e0); wait_done(0);
    sweep(0, 8'h0E, e0); wait_done(0);
    sweep(0, 8'h00, e0); wait_done(0);

    // Stuck-at-1 against the NOR table.
    sweep(1, 8'h0F, e0); wait_done(1);

    // Starts during a sweep are ignored; done timing is checked by the monitor.
    sweep(0, 8'h08, e0);
    pulse_at(0, e0 + 3);
    pulse_at(0, e0 + 7);
    wait_done(0);

    // Reset five edges into a sweep aborts it; a fresh sweep then completes.
    sweep(0, 8'h0E, e0);
    while (cyc + 1 < e0 + 5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset(0);
    rst_n = 1'b1;
    qclear(0);
    sweep(0, 8'h08, e0); wait_done(0);

    // 3-input AND with no settle: one vector per cycle.
    sweep(2, 8'h80, e0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("and3_stim_step", int'(stim_3), i);
    end
    wait_done(2);

    // Start held high: the next sweep is accepted one cycle after done.
    gt[2] = 8'h80;
    e0    = cyc + 1;
    qpush(2, model(2, 8'h80, e0));
    qpush(2, model(2, 8'h80, e0 + 9));
    start_v[2] = 1'b1;
    while (cyc < e0 + 9) @(negedge clk);
    start_v[2] = 1'b0;
    check("held_start_done_low", int'(done_v[2]), 0);
    wait_done(2);

    // Random gate tables on every instance.
    repeat (6) begin
      for (int k = 0; k < 3; k++) begin
        sweep(k, 8'($urandom), e0);
        wait_done(k);
      end
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("queue_empty[%0d]", k), qsize(k), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gate_tt_checker
